// File: rtl/hist_eq_cdf_pkg.sv
// Shared constants and elaboration-time helpers for the CDF histogram equaliser.
package hist_eq_cdf_pkg;

   // FSM encodings
   localparam logic [1:0] ST_CLR   = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_SCAN  = 2'd3;

   // din -> dout latency; the datapath below is built as exactly this many flops
   localparam int LAT       = 3;
   // cycles spent letting in-flight histogram RMWs retire before the scan
   localparam int DRAIN_CYC = 2;

   function automatic longint calc_total(input int iw, input int ih);
      return longint'(iw) * longint'(ih);
   endfunction

   // Rounded reciprocal: ((2^dw-1) << frac + total/2) / total
   function automatic longint calc_scale(input int dw, input int frac, input longint total);
      return ((((longint'(1) << dw) - 1) << frac) + total / 2) / total;
   endfunction

endpackage

// File: rtl/hist_eq_cdf_if.sv
// Pixel-stream bus into and out of the equaliser.
interface hist_eq_cdf_if #(
   parameter int DW = 8
);
   logic          din_valid;
   logic [DW-1:0] din;
   logic          vsync;
   logic          eq_en;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          vsync_out;
   logic          lut_ready;
   logic          scan_overrun;

   // upstream / test side
   modport master (
      output din_valid, din, vsync, eq_en,
      input  dout, dout_valid, vsync_out, lut_ready, scan_overrun
   );

   // the equaliser itself
   modport slave (
      input  din_valid, din, vsync, eq_en,
      output dout, dout_valid, vsync_out, lut_ready, scan_overrun
   );
endinterface

// File: rtl/dpram_sync.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module dpram_sync #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [0:(1<<AW)-1];

   // write port plus registered read (old-data on collision)
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/hist_eq_cdf.sv
// CDF-based histogram equaliser. Counts a frame into a histogram RAM,
// turns it into a mapping LUT during vertical blanking, and maps the next
// frame through that LUT with a fixed 3-cycle latency.
module hist_eq_cdf
   import hist_eq_cdf_pkg::*;
#(
   parameter int DW   = 8,
   parameter int IW   = 640,
   parameter int IH   = 512,
   parameter int TW   = 20,
   parameter int FRAC = 24
) (
   input  logic         clk,
   input  logic         rst,
   hist_eq_cdf_if.slave bus
);

   localparam int     NB      = 1 << DW;
   localparam int     CW      = DW + 1;            // holds NB+2
   localparam int     PW      = TW + FRAC + DW;    // product width
   localparam longint TOTAL   = calc_total(IW, IH);
   localparam longint SCALE64 = calc_scale(DW, FRAC, TOTAL);
   localparam logic [DW+FRAC-1:0] SCALE = SCALE64[DW+FRAC-1:0];
   localparam logic [PW:0]        HALF  = (PW+1)'(1) << (FRAC - 1);
   localparam logic [PW:0]        LMAX  = (PW+1)'(NB - 1);

   localparam logic [CW-1:0] CLR_LAST   = CW'(NB - 1);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);
   localparam logic [CW-1:0] SCAN_RDS   = CW'(NB);
   localparam logic [CW-1:0] SCAN_LAST  = CW'(NB + 2);

   // Counters must not wrap on a full frame.
   generate
      if ((longint'(1) << TW) <= TOTAL) begin : g_tw_chk
         $error("hist_eq_cdf: TW too small, 2^TW must exceed IW*IH");
      end
   endgenerate

   // ---------------- control ----------------
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          vsync_q;
   logic          vs_fall;
   logic          pix_run;
   logic          lut_ready;

   assign vs_fall = vsync_q & ~bus.vsync;
   assign pix_run = bus.din_valid & (state == ST_RUN);

   // FSM: CLR sweep -> RUN count -> DRAIN -> SCAN build LUT -> RUN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_CLR;
         cnt       <= '0;
         vsync_q   <= 1'b0;
         lut_ready <= 1'b0;
      end else begin
         vsync_q <= bus.vsync;
         case (state)
            ST_CLR: begin
               if (cnt == CLR_LAST) begin
                  state <= ST_RUN;
                  cnt   <= '0;
               end else cnt <= cnt + 1'b1;
            end
            ST_RUN: begin
               if (vs_fall) begin
                  state <= ST_DRAIN;
                  cnt   <= '0;
               end
            end
            ST_DRAIN: begin
               if (cnt == DRAIN_LAST) begin
                  state <= ST_SCAN;
                  cnt   <= '0;
               end else cnt <= cnt + 1'b1;
            end
            default: begin
               if (cnt == SCAN_LAST) begin
                  state     <= ST_RUN;
                  cnt       <= '0;
                  lut_ready <= 1'b1;
               end else cnt <= cnt + 1'b1;
            end
         endcase
      end
   end

   // ---------------- histogram RMW ----------------
   logic          h_we;
   logic [DW-1:0] h_waddr, h_raddr;
   logic [TW-1:0] h_wdata, h_rdata;
   logic          a_vld, wr_vld;
   logic [DW-1:0] a_bin, wr_bin;
   logic [TW-1:0] wr_data, h_base, h_inc;

   // The write retiring on the same edge as the next read is invisible to
   // that read, so it is forwarded from the last-write register.
   always_comb begin
      h_base = (wr_vld && wr_bin == a_bin) ? wr_data : h_rdata;
      h_inc  = (h_base == {TW{1'b1}}) ? h_base : h_base + TW'(1);
   end

   // Histogram port mux: CLR zeroes, SCAN reads then zeroes, otherwise RMW.
   always_comb begin
      h_we    = a_vld;
      h_waddr = a_bin;
      h_wdata = h_inc;
      h_raddr = bus.din;
      if (state == ST_CLR) begin
         h_we    = 1'b1;
         h_waddr = cnt[DW-1:0];
         h_wdata = '0;
      end else if (state == ST_SCAN) begin
         h_raddr = cnt[DW-1:0];
         h_we    = (cnt < SCAN_RDS);
         h_waddr = cnt[DW-1:0];
         h_wdata = '0;
      end
   end

   // RMW stage and last-write record for forwarding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_vld   <= 1'b0;
         a_bin   <= '0;
         wr_vld  <= 1'b0;
         wr_bin  <= '0;
         wr_data <= '0;
      end else begin
         a_vld   <= pix_run;
         a_bin   <= bus.din;
         wr_vld  <= a_vld;
         wr_bin  <= a_bin;
         wr_data <= h_inc;
      end
   end

   dpram_sync #(.AW(DW), .DW(TW)) u_hist (
      .clk   (clk),
      .we    (h_we),
      .waddr (h_waddr),
      .wdata (h_wdata),
      .raddr (h_raddr),
      .rdata (h_rdata)
   );

   // ---------------- scan: accumulate, scale, round, clamp ----------------
   logic          s1_vld, s2_vld, s3_vld;
   logic [DW-1:0] s1_bin, s2_bin, s3_bin;
   logic [TW-1:0] cdf, cdf_sum;
   logic [TW:0]   cdf_add;
   logic [PW-1:0] prod;
   logic [PW:0]   prod_rnd, lut_full;
   logic [DW-1:0] lut_wdata, lut_rdata;

   // Saturating CDF add and rounded/clamped LUT value
   always_comb begin
      cdf_add   = {1'b0, cdf} + {1'b0, h_rdata};
      cdf_sum   = cdf_add[TW] ? {TW{1'b1}} : cdf_add[TW-1:0];
      prod_rnd  = {1'b0, prod} + HALF;
      lut_full  = prod_rnd >> FRAC;
      lut_wdata = (lut_full > LMAX) ? {DW{1'b1}} : lut_full[DW-1:0];
   end

   // Scan pipeline: read bin -> cdf += hist -> cdf*SCALE -> LUT write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
         s3_vld <= 1'b0;
         s1_bin <= '0;
         s2_bin <= '0;
         s3_bin <= '0;
         cdf    <= '0;
         prod   <= '0;
      end else begin
         s1_vld <= (state == ST_SCAN) && (cnt < SCAN_RDS);
         s1_bin <= cnt[DW-1:0];
         s2_vld <= s1_vld;
         s2_bin <= s1_bin;
         s3_vld <= s2_vld;
         s3_bin <= s2_bin;
         if (state == ST_DRAIN) cdf <= '0;
         else if (s1_vld)       cdf <= cdf_sum;
         if (s2_vld) prod <= PW'(cdf) * PW'(SCALE);
      end
   end

   dpram_sync #(.AW(DW), .DW(DW)) u_lut (
      .clk   (clk),
      .we    (s3_vld),
      .waddr (s3_bin),
      .wdata (lut_wdata),
      .raddr (bus.din),
      .rdata (lut_rdata)
   );

   // ---------------- output pipeline ----------------
   logic [LAT:1]  vld_pipe, vs_pipe;
   logic [DW-1:0] p1_din, p2_map, dout_r;
   logic          p1_use, ovr_r;

   // Three flops din->dout: LUT read, select, output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         vs_pipe  <= '0;
         p1_din   <= '0;
         p1_use   <= 1'b0;
         p2_map   <= '0;
         dout_r   <= '0;
         ovr_r    <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[LAT-1:1], bus.din_valid};
         vs_pipe  <= {vs_pipe[LAT-1:1], bus.vsync};
         p1_din   <= bus.din;
         p1_use   <= bus.eq_en & lut_ready;
         p2_map   <= p1_use ? lut_rdata : p1_din;
         dout_r   <= p2_map;
         ovr_r    <= bus.din_valid & ((state == ST_DRAIN) | (state == ST_SCAN));
      end
   end

   assign bus.dout         = dout_r;
   assign bus.dout_valid   = vld_pipe[LAT];
   assign bus.vsync_out    = vs_pipe[LAT];
   assign bus.lut_ready    = lut_ready;
   assign bus.scan_overrun = ovr_r;

endmodule

// File: tb/tb_hist_eq_cdf.sv
// Directed scoreboard bench for hist_eq_cdf (DW=8, 4x4 frames).
module tb_hist_eq_cdf;
   localparam int DW = 8, IW = 4, IH = 4, TW = 20, FRAC = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hist_eq_cdf_if #(.DW(DW)) bus ();

   hist_eq_cdf #(.DW(DW), .IW(IW), .IH(IH), .TW(TW), .FRAC(FRAC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int rst_age = 0;
   logic [3:0] vs_hist = '0;
   logic [7:0] exp_q[$];
   int         t_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      vs_hist <= {vs_hist[2:0], bus.vsync};
      rst_age <= rst ? 0 : rst_age + 1;
   end

   // monitor: pop expected pixel on every dout_valid, check value and latency
   always @(negedge clk) begin
      logic [7:0] e;
      int t;
      if (!rst && rst_age >= 3) check("vsync_out", 32'(bus.vsync_out), 32'(vs_hist[2]));
      if (bus.dout_valid) begin
         if (exp_q.size() == 0) check("unexpected dout_valid", 1, 0);
         else begin
            e = exp_q.pop_front();
            t = t_q.pop_front();
            check("dout", 32'(bus.dout), 32'(e));
            check("latency", 32'(cyc - t), 3);
         end
      end
   end

   task automatic pix(input logic [7:0] v, input logic en, input logic [7:0] e);
      @(negedge clk);
      bus.din_valid = 1'b1;
      bus.din       = v;
      bus.eq_en     = en;
      exp_q.push_back(e);
      t_q.push_back(cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.din_valid = 1'b0;
      end
   endtask

   task automatic frame_start;
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.vsync     = 1'b1;
   endtask

   task automatic frame_end;
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.vsync     = 1'b0;
   endtask

   task automatic chk_outs_zero(input string tag);
      check({tag, " dout"},         32'(bus.dout), 0);
      check({tag, " dout_valid"},   32'(bus.dout_valid), 0);
      check({tag, " vsync_out"},    32'(bus.vsync_out), 0);
      check({tag, " lut_ready"},    32'(bus.lut_ready), 0);
      check({tag, " scan_overrun"}, 32'(bus.scan_overrun), 0);
   endtask

   initial begin
      bus.din_valid = 1'b0;
      bus.din       = '0;
      bus.vsync     = 1'b0;
      bus.eq_en     = 1'b0;
      rst           = 1'b1;
      repeat (3) @(negedge clk);
      chk_outs_zero("reset");
      rst = 1'b0;
      idle(300);                       // CLR sweep

      // 1: first frame is bypassed even with eq_en=1
      check("lut_ready before first scan", 32'(bus.lut_ready), 0);
      frame_start();
      for (int i = 0; i < 16; i++) pix(8'd100, 1'b1, 8'd100);
      frame_end();
      check("lut_ready during first drain", 32'(bus.lut_ready), 0);
      idle(300);
      check("lut_ready after first scan", 32'(bus.lut_ready), 1);

      // 2: all-100 histogram maps 100->255, 50->0
      frame_start();
      for (int i = 0; i < 16; i++)
         if (i % 2 == 0) pix(8'd100, 1'b1, 8'd255);
         else            pix(8'd50,  1'b1, 8'd0);
      frame_end();
      idle(300);

      // 3: ramp 0..15 (still mapped via LUT from 100/50 frame -> 0)
      frame_start();
      for (int i = 0; i < 16; i++) pix(8'(i), 1'b1, 8'd0);
      frame_end();
      idle(300);
      // ramp LUT: 0->16, 7->128, 15->255; this frame has 6x0, 5x7, 5x15
      frame_start();
      for (int i = 0; i < 16; i++)
         case (i % 3)
            0:       pix(8'd0,  1'b1, 8'd16);
            1:       pix(8'd7,  1'b1, 8'd128);
            default: pix(8'd15, 1'b1, 8'd255);
         endcase
      frame_end();
      idle(300);

      // 4: 16 back-to-back 7s; previous LUT gives 7 -> cdf 11 -> 175
      frame_start();
      for (int i = 0; i < 16; i++) pix(8'd7, 1'b1, 8'd175);
      frame_end();
      idle(300);
      frame_start();
      for (int i = 0; i < 16; i++)
         if (i % 2 == 0) pix(8'd7, 1'b1, 8'd255);
         else            pix(8'd6, 1'b1, 8'd0);
      frame_end();

      // 5: next frame starts mid-scan; 200 maps to 255 in old and new LUT
      idle(10);
      frame_start();
      check("scan_overrun idle", 32'(bus.scan_overrun), 0);
      pix(8'd200, 1'b1, 8'd255);
      pix(8'd200, 1'b1, 8'd255);
      check("scan_overrun first overrun pixel", 32'(bus.scan_overrun), 1);
      pix(8'd200, 1'b1, 8'd255);
      pix(8'd200, 1'b1, 8'd255);
      idle(300);
      check("lut_ready after overrun scan", 32'(bus.lut_ready), 1);
      // LUT from 8x7/8x6 frame: 6 -> cdf 8 -> 128
      pix(8'd6, 1'b1, 8'd128);
      pix(8'd6, 1'b1, 8'd128);
      check("scan_overrun in RUN", 32'(bus.scan_overrun), 0);
      for (int i = 0; i < 14; i++) pix(8'd6, 1'b1, 8'd128);
      frame_end();

      // 6: reset mid-scan
      idle(100);
      rst = 1'b1;
      @(negedge clk);
      chk_outs_zero("mid-scan reset");
      @(negedge clk);
      rst = 1'b0;
      idle(300);
      frame_start();
      for (int i = 0; i < 16; i++)
         if (i % 2 == 0) pix(8'd6, 1'b1, 8'd6);
         else            pix(8'd6, 1'b0, 8'd6);
      check("lut_ready after reset", 32'(bus.lut_ready), 0);
      frame_end();
      idle(300);
      check("lut_ready after post-reset scan", 32'(bus.lut_ready), 1);
      // LUT from all-6 frame: <6 -> 0, >=6 -> 255; eq_en=0 passes din
      frame_start();
      for (int i = 0; i < 16; i++)
         case (i % 4)
            0:       pix(8'd123, 1'b1, 8'd255);
            1:       pix(8'd123, 1'b0, 8'd123);
            2:       pix(8'd5,   1'b1, 8'd0);
            default: pix(8'd5,   1'b0, 8'd5);
         endcase
      frame_end();
      idle(20);
      check("scoreboard drained", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
